// File: rtl/ram_refresh_pkg.sv
// Shared types and default timing for the CAS-before-RAS refresh sequencer.
// Phase lengths are in FSB clock cycles.
package ram_refresh_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CAS,
      RAS,
      PRE
   } state_t;

   localparam int DEF_TCSR  = 1;
   localparam int DEF_TRAS  = 3;
   localparam int DEF_TRP   = 2;
   localparam int DEF_MISSW = 8;

   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/ram_ref_phase_timer.sv
// Loadable down-counter timing one refresh phase.
// tc is high while the count sits at zero.
module ram_ref_phase_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/ram_refresh_seq.sv
// CAS-before-RAS refresh sequencer: one refresh per request window,
// opportunistic on an idle bus, forced under RefUrg, misses counted.
module ram_refresh_seq
   import ram_refresh_pkg::*;
#(
   parameter int TCSR  = DEF_TCSR,
   parameter int TRAS  = DEF_TRAS,
   parameter int TRP   = DEF_TRP,
   parameter int MISSW = DEF_MISSW
) (
   input  logic             CLK,
   input  logic             nRES,
   input  logic             RefReq,
   input  logic             RefUrg,
   input  logic             BACT,
   input  logic             RAMCS,
   output logic             RAMHold,
   output logic             nRAS,
   output logic             nCAS,
   output logic             RefBusy,
   output logic             RefMiss,
   output logic [MISSW-1:0] MissCnt
);

   localparam int TW = timer_width(TCSR, TRAS, TRP);

   state_t        state;
   state_t        state_n;
   logic          req_r;
   logic          pend;
   logic          rise;
   logic          fall;
   logic          bus_free;
   logic          start;
   logic          miss;
   logic          load;
   logic [TW-1:0] load_val;
   logic          tc;

   assign rise = RefReq & ~req_r;
   assign fall = ~RefReq & req_r;

   // Under urgency only a RAM cycle blocks; otherwise wait for a quiet bus.
   assign bus_free = RefUrg ? ~(BACT & RAMCS) : ~BACT;
   assign start    = (state == IDLE) & pend & bus_free;
   assign miss     = fall & pend & ~start;

   ram_ref_phase_timer #(
      .W(TW)
   ) u_timer (
      .clk      (CLK),
      .rst_n    (nRES),
      .load     (load),
      .load_val (load_val),
      .tc       (tc)
   );

   always_comb begin
      state_n  = state;
      load     = 1'b0;
      load_val = '0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n  = CAS;
               load     = 1'b1;
               load_val = TW'(TCSR - 1);
            end
         end
         CAS: begin
            if (tc) begin
               state_n  = RAS;
               load     = 1'b1;
               load_val = TW'(TRAS - 1);
            end
         end
         RAS: begin
            if (tc) begin
               state_n  = PRE;
               load     = 1'b1;
               load_val = TW'(TRP - 1);
            end
         end
         PRE: begin
            if (tc) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRES) begin
         state   <= IDLE;
         req_r   <= 1'b0;
         pend    <= 1'b0;
         RAMHold <= 1'b0;
         nRAS    <= 1'b1;
         nCAS    <= 1'b1;
         RefBusy <= 1'b0;
         RefMiss <= 1'b0;
         MissCnt <= '0;
      end else begin
         state   <= state_n;
         req_r   <= RefReq;
         RAMHold <= pend & RefUrg;
         RefMiss <= miss;
         if (rise) begin
            pend <= 1'b1;
         end else if (start || miss) begin
            pend <= 1'b0;
         end
         if (miss && (MissCnt != '1)) begin
            MissCnt <= MissCnt + 1'b1;
         end
         // Strobes follow the next state so they leave the flops clean.
         nCAS    <= ~((state_n == CAS) || (state_n == RAS));
         nRAS    <= ~(state_n == RAS);
         RefBusy <= (state_n != IDLE);
      end
   end

endmodule
